// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        LD_PRI  = 1'b0,
        ALU_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter (ALU vs load unit) driving a single register-bank write port.
// Loads win contention until an ALU request has waited STARVE_LIMIT load grants.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  freeze,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write,
    output logic [XLEN-1:0]       data
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW:0] Limit = (CntW + 1)'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW:0]         cnt_inc;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] write_q, write_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  grant_alu, grant_ld;

    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (!rst && !freeze) begin
            if (alu_valid && ld_valid) begin
                grant_alu = (state_q == ALU_PRI);
                grant_ld  = (state_q == LD_PRI);
            end else begin
                grant_alu = alu_valid;
                grant_ld  = ld_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;

    assign cnt_inc = {1'b0, cnt_q} + (CntW + 1)'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        write_d = write_q;
        data_d  = data_q;

        // Frozen cycles leave the starvation history untouched.
        if (!freeze) begin
            if (grant_alu || !alu_valid) begin
                state_d = LD_PRI;
                cnt_d   = '0;
            end else if (grant_ld) begin
                cnt_d = cnt_inc[CntW-1:0];
                if (cnt_inc == Limit) begin
                    state_d = ALU_PRI;
                end
            end
        end

        // x0 is accepted and arbitrated but never reaches the bank.
        if (grant_alu) begin
            we_d    = (alu_rd != REG_X0);
            write_d = alu_rd;
            data_d  = alu_data;
        end else if (grant_ld) begin
            we_d    = (ld_rd != REG_X0);
            write_d = ld_rd;
            data_d  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_PRI;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            write_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign write_enable = we_q;
    assign write        = write_q;
    assign data         = data_q;

endmodule
